// File: rtl/ddr_multibank_dimm_model_if.sv
// Command/data bus between a DDR4 controller (master) and the DIMM model (slave).
// One command per CK_t edge; one data beat per cycle in each direction.
interface ddr_multibank_dimm_model_if #(
    parameter int NUM_BG = 2,
    parameter int NUM_BA = 4,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 7,
    parameter int DQ_W   = 8
);
    localparam int BG_W = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;
    localparam int BA_W = (NUM_BA > 1) ? $clog2(NUM_BA) : 1;
    localparam int A_W  = (ROW_W > COL_W) ? ROW_W : COL_W;

    logic                     cs_n;
    logic                     act_n;
    logic                     RAS_n_A16;
    logic                     CAS_n_A15;
    logic                     WE_n_A14;
    logic [BG_W-1:0]          bg_addr;
    logic [BA_W-1:0]          ba_addr;
    logic                     A12_BC_n;
    logic                     A10_AP;
    logic [A_W-1:0]           addr;
    logic [DQ_W-1:0]          dq_in;
    logic [DQ_W-1:0]          dq_out;
    logic                     dq_rd_valid;
    logic                     dq_wr_strobe;
    logic [NUM_BG*NUM_BA-1:0] bank_open;
    logic [2:0]               err_code;

    modport master (
        output cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, bg_addr, ba_addr,
               A12_BC_n, A10_AP, addr, dq_in,
        input  dq_out, dq_rd_valid, dq_wr_strobe, bank_open, err_code
    );

    modport slave (
        input  cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, bg_addr, ba_addr,
               A12_BC_n, A10_AP, addr, dq_in,
        output dq_out, dq_rd_valid, dq_wr_strobe, bank_open, err_code
    );
endinterface

// File: rtl/ddr_multibank_dimm_model.sv
// DDR4 DIMM model: per-bank open-row tracking, CL/CWL-scheduled bursts via a pending-CAS queue; DIMM_AUTO_PRE_EN enables RD/WR auto-precharge.
// Latency: first read beat CL cycles, first write strobe CWL cycles after the CAS edge; err_code one cycle after the command.
// Backpressure: none on the command bus; a full queue drops the CAS with err_code=3, a late head waits with err_code=4.
module ddr_multibank_dimm_model #(
    parameter int NUM_BG = 2,
    parameter int NUM_BA = 4,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 7,
    parameter int DQ_W   = 8,
    parameter int CL     = 11,
    parameter int CWL    = 9,
    parameter int QDEPTH = 4,
    parameter int TRFC   = 16
) (
    input  logic                      CK_t,
    input  logic                      reset,
    ddr_multibank_dimm_model_if.slave bus
);
    localparam int BG_W   = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;
    localparam int BA_W   = (NUM_BA > 1) ? $clog2(NUM_BA) : 1;
    localparam int NB     = NUM_BG * NUM_BA;
    localparam int NB_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int LAT    = (CL > CWL) ? CL : CWL;
    localparam int CNT_W  = $clog2(LAT);
    localparam int QW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int RF_W   = $clog2(TRFC + 1);
    localparam int MEM_AW = BG_W + BA_W + ROW_W + COL_W;

    typedef enum logic [1:0] {MODE_BL8 = 2'b00, MODE_OTF = 2'b01, MODE_BC4 = 2'b10} mode_t;

    typedef struct packed {
        logic             rd;
        logic [BG_W-1:0]  bg;
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             bc4;
        logic             ap;
    } cas_t;

    function automatic logic [NB_W-1:0] bank_idx(input logic [BG_W-1:0] bg, input logic [BA_W-1:0] ba);
        return NB_W'(int'(bg) * NUM_BA + int'(ba));
    endfunction

    logic [NB-1:0]     bank_open;
    logic [ROW_W-1:0]  bank_row [NB];
    cas_t              q_ent    [QDEPTH];
    logic [CNT_W-1:0]  q_cnt    [QDEPTH];
    logic [QDEPTH-1:0] q_vld;
    logic [QW-1:0]     q_head, q_tail;
    cas_t              bst;
    logic              bst_vld;
    logic [2:0]        bst_beat;
    logic              late_flag;
    logic [RF_W-1:0]   ref_cnt;
    mode_t             mode;
    logic [2:0]        err_code;
    logic [DQ_W-1:0]   mem [2**MEM_AW];

    logic cmd_act, cmd_mrs, cmd_ref, cmd_pre, cmd_wr, cmd_rd;
    logic [NB_W-1:0]   cmd_bank;
    logic [2:0]        cmd_err;
    logic              push, act_ap_block;
    cas_t              new_ent;
    logic              head_due, last_beat, launch, late;
    logic [2:0]        beat_lo;
    logic [COL_W-1:0]  beat_col;
    logic [MEM_AW-1:0] mem_addr;

    assign cmd_bank  = bank_idx(bus.bg_addr, bus.ba_addr);
    assign head_due  = q_vld[q_head] && (q_cnt[q_head] == '0);
    assign last_beat = bst_vld && (bst_beat == (bst.bc4 ? 3'd3 : 3'd7));
    // Back-to-back launch on the last beat keeps the data bus bubble-free.
    assign launch    = head_due && (!bst_vld || last_beat);
    assign late      = head_due && !launch && !late_flag;

    // Beats wrap inside the aligned 8-column block.
    assign beat_lo   = bst.col[2:0] + bst_beat;
    assign beat_col  = (bst.col & ~COL_W'(7)) | COL_W'(beat_lo);
    assign mem_addr  = {bst.bg, bst.ba, bst.row, beat_col};

    always_comb begin
        act_ap_block = 1'b0;
`ifdef DIMM_AUTO_PRE_EN
        if (bst_vld && bst.ap && bank_idx(bst.bg, bst.ba) == cmd_bank)
            act_ap_block = 1'b1;
        for (int i = 0; i < QDEPTH; i++)
            if (q_vld[i] && q_ent[i].ap && bank_idx(q_ent[i].bg, q_ent[i].ba) == cmd_bank)
                act_ap_block = 1'b1;
`endif
    end

    always_comb begin
        cmd_act = 1'b0; cmd_mrs = 1'b0; cmd_ref = 1'b0;
        cmd_pre = 1'b0; cmd_wr  = 1'b0; cmd_rd  = 1'b0;
        if (!bus.cs_n) begin
            if (!bus.act_n) cmd_act = 1'b1;
            else begin
                case ({bus.RAS_n_A16, bus.CAS_n_A15, bus.WE_n_A14})
                    3'b000:  cmd_mrs = 1'b1;
                    3'b001:  cmd_ref = 1'b1;
                    3'b010:  cmd_pre = 1'b1;
                    3'b100:  cmd_wr  = 1'b1;
                    3'b101:  cmd_rd  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cmd_err = 3'd0;
        push    = 1'b0;
        new_ent.rd  = cmd_rd;
        new_ent.bg  = bus.bg_addr;
        new_ent.ba  = bus.ba_addr;
        new_ent.row = bank_row[cmd_bank];
        new_ent.col = bus.addr[COL_W-1:0];
        new_ent.bc4 = (mode == MODE_BC4) || (mode == MODE_OTF && !bus.A12_BC_n);
`ifdef DIMM_AUTO_PRE_EN
        new_ent.ap  = bus.A10_AP;
`else
        new_ent.ap  = 1'b0;
`endif
        if ((cmd_act | cmd_mrs | cmd_ref | cmd_pre | cmd_wr | cmd_rd) && ref_cnt != '0)
            cmd_err = 3'd6;
        else if (cmd_act && (bank_open[cmd_bank] || act_ap_block))
            cmd_err = 3'd1;
        else if ((cmd_rd || cmd_wr) && !bank_open[cmd_bank])
            cmd_err = 3'd2;
        else if (cmd_rd || cmd_wr) begin
            if (q_vld[q_tail] && !launch) cmd_err = 3'd3;
            else                          push    = 1'b1;
        end
        else if (cmd_ref && bank_open != '0)
            cmd_err = 3'd5;
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            bank_open <= '0;
            q_vld     <= '0;
            q_head    <= '0;
            q_tail    <= '0;
            bst_vld   <= 1'b0;
            bst_beat  <= '0;
            late_flag <= 1'b0;
            ref_cnt   <= '0;
            mode      <= MODE_BL8;
            err_code  <= '0;
        end else begin
            err_code <= (cmd_err != 3'd0) ? cmd_err : (late ? 3'd4 : 3'd0);
            // A late pulse hidden by a command error is reported next cycle.
            if (late && cmd_err == 3'd0) late_flag <= 1'b1;
            if (launch) begin
                q_vld[q_head] <= 1'b0;
                q_head        <= q_head + QW'(1);
                late_flag     <= 1'b0;
                bst_vld       <= 1'b1;
                bst_beat      <= '0;
            end else if (bst_vld) begin
                if (last_beat) bst_vld  <= 1'b0;
                else           bst_beat <= bst_beat + 3'd1;
            end
            if (push) begin
                q_vld[q_tail] <= 1'b1;
                q_tail        <= q_tail + QW'(1);
            end
`ifdef DIMM_AUTO_PRE_EN
            if (last_beat && bst.ap) bank_open[bank_idx(bst.bg, bst.ba)] <= 1'b0;
`endif
            if (cmd_err == 3'd0) begin
                if (cmd_act) bank_open[cmd_bank] <= 1'b1;
                if (cmd_pre) begin
                    if (bus.A10_AP) bank_open <= '0;
                    else            bank_open[cmd_bank] <= 1'b0;
                end
                if (cmd_mrs) mode <= (bus.addr[1:0] == 2'b11) ? MODE_BL8 : mode_t'(bus.addr[1:0]);
            end
            if (cmd_ref && cmd_err == 3'd0) ref_cnt <= RF_W'(TRFC);
            else if (ref_cnt != '0)         ref_cnt <= ref_cnt - RF_W'(1);
        end
    end

    // Array, queue payload and row registers survive reset; validity bits gate them.
    always_ff @(posedge CK_t) begin
        for (int i = 0; i < QDEPTH; i++)
            if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - CNT_W'(1);
        if (push) begin
            q_ent[q_tail] <= new_ent;
            q_cnt[q_tail] <= cmd_rd ? CNT_W'(CL - 1) : CNT_W'(CWL - 1);
        end
        if (launch) bst <= q_ent[q_head];
        if (cmd_act && cmd_err == 3'd0) bank_row[cmd_bank] <= bus.addr[ROW_W-1:0];
        if (bst_vld && !bst.rd && !reset) mem[mem_addr] <= bus.dq_in;
    end

`ifndef DIMM_AUTO_PRE_EN
    logic unused_ap;
    assign unused_ap = bst.ap;
`endif

    assign bus.dq_rd_valid  = bst_vld & bst.rd;
    assign bus.dq_wr_strobe = bst_vld & ~bst.rd;
    assign bus.dq_out       = (bst_vld & bst.rd) ? mem[mem_addr] : '0;
    assign bus.bank_open    = bank_open;
    assign bus.err_code     = err_code;
endmodule

// File: tb/tb_ddr_multibank_dimm_model.sv
// Directed bench for ddr_multibank_dimm_model: commands go out one per edge, outputs are sampled 1ns after the edge.
// Offsets are counted in edges after the command edge (offset 0 = just after the command was sampled).
module tb_ddr_multibank_dimm_model;
    localparam int CL   = 11;
    localparam int CWL  = 9;
    localparam int TRFC = 16;

    logic CK_t  = 1'b0;
    logic reset = 1'b1;
    always #5 CK_t = ~CK_t;

    ddr_multibank_dimm_model_if bus_if ();
    ddr_multibank_dimm_model dut (.CK_t(CK_t), .reset(reset), .bus(bus_if));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] wq    [64];
    logic [7:0] rdat  [64];
    logic [2:0] obs_e [64];
    logic [7:0] obs_b [64];
    int fv, lv, vc, fs, sc;

    task automatic tick();
        @(posedge CK_t);
        #1;
    endtask

    task automatic cmd(input logic a_n, input logic [2:0] rcw, input logic bg, input logic [1:0] ba,
                       input logic [7:0] a, input logic bc_n, input logic ap);
        bus_if.cs_n = 1'b0; bus_if.act_n = a_n;
        {bus_if.RAS_n_A16, bus_if.CAS_n_A15, bus_if.WE_n_A14} = rcw;
        bus_if.bg_addr = bg; bus_if.ba_addr = ba; bus_if.addr = a;
        bus_if.A12_BC_n = bc_n; bus_if.A10_AP = ap;
        tick();
        bus_if.cs_n = 1'b1; bus_if.act_n = 1'b1;
        {bus_if.RAS_n_A16, bus_if.CAS_n_A15, bus_if.WE_n_A14} = 3'b111;
        bus_if.A12_BC_n = 1'b1; bus_if.A10_AP = 1'b0;
    endtask

    task automatic act(input logic bg, input logic [1:0] ba, input logic [7:0] row);
        cmd(1'b0, 3'b000, bg, ba, row, 1'b1, 1'b0);
    endtask
    task automatic rd(input logic bg, input logic [1:0] ba, input logic [7:0] col, input logic bc_n, input logic ap);
        cmd(1'b1, 3'b101, bg, ba, col, bc_n, ap);
    endtask
    task automatic wr(input logic bg, input logic [1:0] ba, input logic [7:0] col, input logic bc_n, input logic ap);
        cmd(1'b1, 3'b100, bg, ba, col, bc_n, ap);
    endtask

    task automatic clear_wq();
        for (int i = 0; i < 64; i++) wq[i] = 8'h00;
    endtask

    // Advance n edges, recording outputs and driving dq_in from wq at each offset.
    task automatic watch(input int n);
        fv = -1; lv = -1; vc = 0; fs = -1; sc = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            obs_e[k] = bus_if.err_code;
            obs_b[k] = bus_if.bank_open;
            if (bus_if.dq_rd_valid === 1'b1) begin
                if (fv < 0) fv = k;
                lv = k;
                if (vc < 64) rdat[vc] = bus_if.dq_out;
                vc++;
            end
            if (bus_if.dq_wr_strobe === 1'b1) begin
                if (fs < 0) fs = k;
                sc++;
            end
            bus_if.dq_in = wq[k];
        end
        bus_if.dq_in = 8'h00;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_tests++; if (bus_if.dq_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus_if.dq_rd_valid); end
        n_tests++; if (bus_if.dq_wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe got %b want 0", bus_if.dq_wr_strobe); end
        n_tests++; if (bus_if.bank_open !== 8'h00) begin n_fail++; $display("FAIL reset_bank_open got %h want 00", bus_if.bank_open); end
        n_tests++; if (bus_if.err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", bus_if.err_code); end
        n_tests++; if (bus_if.dq_out !== 8'h00) begin n_fail++; $display("FAIL reset_dq_out got %h want 00", bus_if.dq_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        act(1'b0, 2'd1, 8'h3C);
        n_tests++; if (bus_if.err_code !== 3'd0) begin n_fail++; $display("FAIL wr_act_err got %0d want 0", bus_if.err_code); end
        n_tests++; if (bus_if.bank_open !== 8'h02) begin n_fail++; $display("FAIL wr_act_open got %h want 02", bus_if.bank_open); end
        clear_wq();
        for (int j = 0; j < 8; j++) wq[CWL + j] = 8'(j + 1);
        wr(1'b0, 2'd1, 8'h10, 1'b1, 1'b0);
        watch(CWL + 10);
        n_tests++; if (fs !== CWL) begin n_fail++; $display("FAIL wr_first_strobe got %0d want %0d", fs, CWL); end
        n_tests++; if (sc !== 8) begin n_fail++; $display("FAIL wr_strobe_count got %0d want 8", sc); end
        clear_wq();
        rd(1'b0, 2'd1, 8'h10, 1'b1, 1'b0);
        watch(CL + 10);
        n_tests++; if (fv !== CL) begin n_fail++; $display("FAIL rd_first_valid got %0d want %0d", fv, CL); end
        n_tests++; if (vc !== 8) begin n_fail++; $display("FAIL rd_valid_count got %0d want 8", vc); end
        for (int j = 0; j < 8 && j < vc; j++) begin
            n_tests++;
            if (rdat[j] !== 8'(j + 1)) begin n_fail++; $display("FAIL rd_data[%0d] got %h want %h", j, rdat[j], 8'(j + 1)); end
        end
    endtask

    task automatic test_otf_bc4();
        logic [7:0] exp4 [4];
        exp4 = '{8'hA4, 8'h02, 8'h03, 8'h04};
        cmd(1'b1, 3'b000, 1'b0, 2'd0, 8'h01, 1'b1, 1'b0);
        n_tests++; if (bus_if.err_code !== 3'd0) begin n_fail++; $display("FAIL mrs_err got %0d want 0", bus_if.err_code); end
        clear_wq();
        for (int j = 0; j < 4; j++) wq[CWL + j] = 8'hA1 + 8'(j);
        wr(1'b0, 2'd1, 8'h15, 1'b0, 1'b0);
        watch(CWL + 10);
        n_tests++; if (fs !== CWL) begin n_fail++; $display("FAIL bc4_wr_first got %0d want %0d", fs, CWL); end
        n_tests++; if (sc !== 4) begin n_fail++; $display("FAIL bc4_wr_count got %0d want 4", sc); end
        clear_wq();
        rd(1'b0, 2'd1, 8'h10, 1'b0, 1'b0);
        watch(CL + 10);
        n_tests++; if (vc !== 4) begin n_fail++; $display("FAIL bc4_rd_count got %0d want 4", vc); end
        for (int j = 0; j < 4 && j < vc; j++) begin
            n_tests++;
            if (rdat[j] !== exp4[j]) begin n_fail++; $display("FAIL bc4_rd_data[%0d] got %h want %h", j, rdat[j], exp4[j]); end
        end
    endtask

    task automatic test_errors();
        rd(1'b1, 2'd0, 8'h00, 1'b1, 1'b0);
        n_tests++; if (bus_if.err_code !== 3'd2) begin n_fail++; $display("FAIL closed_rd_err got %0d want 2", bus_if.err_code); end
        watch(CL + 4);
        n_tests++; if (obs_e[1] !== 3'd0) begin n_fail++; $display("FAIL closed_rd_pulse got %0d want 0", obs_e[1]); end
        n_tests++; if (vc !== 0) begin n_fail++; $display("FAIL closed_rd_valid got %0d beats want 0", vc); end
        act(1'b0, 2'd1, 8'h55);
        n_tests++; if (bus_if.err_code !== 3'd1) begin n_fail++; $display("FAIL act_open_err got %0d want 1", bus_if.err_code); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp8 [8];
        logic [2:0] e5   [5];
        int n4;
        exp8 = '{8'hA4, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 5; i++) begin
            rd(1'b0, 2'd1, 8'h10, 1'b1, 1'b0);
            e5[i] = bus_if.err_code;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (e5[i] !== 3'd0) begin n_fail++; $display("FAIL b2b_push_err[%0d] got %0d want 0", i, e5[i]); end
        end
        n_tests++; if (e5[4] !== 3'd3) begin n_fail++; $display("FAIL b2b_full_err got %0d want 3", e5[4]); end
        watch(45);
        n_tests++; if (fv !== 7) begin n_fail++; $display("FAIL b2b_first_valid got %0d want 7", fv); end
        n_tests++; if (lv !== 38) begin n_fail++; $display("FAIL b2b_last_valid got %0d want 38", lv); end
        n_tests++; if (vc !== 32) begin n_fail++; $display("FAIL b2b_valid_count got %0d want 32", vc); end
        for (int j = 0; j < 32 && j < vc; j++) begin
            n_tests++;
            if (rdat[j] !== exp8[j % 8]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", j, rdat[j], exp8[j % 8]); end
        end
        n4 = 0;
        for (int k = 1; k <= 45; k++) if (obs_e[k] === 3'd4) n4++;
        n_tests++; if (n4 !== 3) begin n_fail++; $display("FAIL b2b_late_count got %0d want 3", n4); end
        n_tests++; if (obs_e[8] !== 3'd4) begin n_fail++; $display("FAIL b2b_late_at8 got %0d want 4", obs_e[8]); end
        n_tests++; if (obs_e[16] !== 3'd4) begin n_fail++; $display("FAIL b2b_late_at16 got %0d want 4", obs_e[16]); end
        n_tests++; if (obs_e[24] !== 3'd4) begin n_fail++; $display("FAIL b2b_late_at24 got %0d want 4", obs_e[24]); end
    endtask

    task automatic test_refresh();
        cmd(1'b1, 3'b001, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        n_tests++; if (bus_if.err_code !== 3'd5) begin n_fail++; $display("FAIL ref_open_err got %0d want 5", bus_if.err_code); end
        cmd(1'b1, 3'b010, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
        n_tests++; if (bus_if.bank_open !== 8'h00) begin n_fail++; $display("FAIL pre_all got %h want 00", bus_if.bank_open); end
        cmd(1'b1, 3'b001, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        n_tests++; if (bus_if.err_code !== 3'd0) begin n_fail++; $display("FAIL ref_idle_err got %0d want 0", bus_if.err_code); end
        for (int k = 1; k <= 4; k++) tick();
        act(1'b1, 2'd2, 8'h11);
        n_tests++; if (bus_if.err_code !== 3'd6) begin n_fail++; $display("FAIL ref_busy5_err got %0d want 6", bus_if.err_code); end
        n_tests++; if (bus_if.bank_open !== 8'h00) begin n_fail++; $display("FAIL ref_busy5_open got %h want 00", bus_if.bank_open); end
        for (int k = 6; k <= TRFC - 1; k++) tick();
        act(1'b1, 2'd2, 8'h11);
        n_tests++; if (bus_if.err_code !== 3'd6) begin n_fail++; $display("FAIL ref_busy_last_err got %0d want 6", bus_if.err_code); end
        act(1'b1, 2'd2, 8'h11);
        n_tests++; if (bus_if.err_code !== 3'd0) begin n_fail++; $display("FAIL ref_done_err got %0d want 0", bus_if.err_code); end
        n_tests++; if (bus_if.bank_open !== 8'h40) begin n_fail++; $display("FAIL ref_done_open got %h want 40", bus_if.bank_open); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic exp_open;
        act(1'b0, 2'd1, 8'h3C);
        rd(1'b0, 2'd1, 8'h10, 1'b1, 1'b0);
        for (int k = 1; k <= CL + 2; k++) tick();
        n_tests++; if (bus_if.dq_rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_beat3_valid got %b want 1", bus_if.dq_rd_valid); end
        n_tests++; if (bus_if.dq_out !== 8'h03) begin n_fail++; $display("FAIL mid_beat3_data got %h want 03", bus_if.dq_out); end
        reset = 1'b1;
        tick();
        n_tests++; if (bus_if.dq_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b want 0", bus_if.dq_rd_valid); end
        n_tests++; if (bus_if.bank_open !== 8'h00) begin n_fail++; $display("FAIL mid_reset_open got %h want 00", bus_if.bank_open); end
        reset = 1'b0;
        tick();
        act(1'b0, 2'd1, 8'h3C);
        rd(1'b0, 2'd1, 8'h10, 1'b0, 1'b1);
        watch(CL + 10);
        n_tests++; if (vc !== 8) begin n_fail++; $display("FAIL ap_bl8_after_reset got %0d beats want 8", vc); end
        n_tests++; if (rdat[0] !== 8'hA4) begin n_fail++; $display("FAIL ap_retained_data got %h want a4", rdat[0]); end
        n_tests++; if (obs_b[CL + 7][1] !== 1'b1) begin n_fail++; $display("FAIL ap_open_last_beat got %b want 1", obs_b[CL + 7][1]); end
`ifdef DIMM_AUTO_PRE_EN
        exp_open = 1'b0;
`else
        exp_open = 1'b1;
`endif
        n_tests++; if (obs_b[CL + 8][1] !== exp_open) begin n_fail++; $display("FAIL ap_open_after got %b want %b", obs_b[CL + 8][1], exp_open); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bus_if.cs_n = 1'b1; bus_if.act_n = 1'b1;
        bus_if.RAS_n_A16 = 1'b1; bus_if.CAS_n_A15 = 1'b1; bus_if.WE_n_A14 = 1'b1;
        bus_if.bg_addr = '0; bus_if.ba_addr = '0; bus_if.addr = '0;
        bus_if.A12_BC_n = 1'b1; bus_if.A10_AP = 1'b0; bus_if.dq_in = '0;
        clear_wq();
        test_reset();
        test_write_read();
        test_otf_bc4();
        test_errors();
        test_back_to_back();
        test_refresh();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
